// File: rtl/tc_pkg.sv
// Shared tensor-core types and layout helpers for the result drain.
// The TC_DRAIN_RELU_EN build option is consumed by tc_row_select.
package tc_pkg;

   localparam int DIM       = 4;
   localparam int ACC_WIDTH = 32;
   localparam int ROW_W     = DIM * ACC_WIDTH;
   localparam int MAT_W     = DIM * DIM * ACC_WIDTH;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   typedef logic [ROW_W-1:0]            row_t;
   typedef logic [MAT_W-1:0]            mat_t;

   // Occupancy of the ping-pong buffer doubles as the drain state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } drain_state_t;

   localparam logic [1:0] LAST_ROW = 2'(DIM - 1);

   // Bit offset of element (i,j) inside a flattened DIM x DIM matrix.
   function automatic int idx(input int i, input int j);
      return (i * DIM + j) * ACC_WIDTH;
   endfunction

endpackage

// File: rtl/tc_row_select.sv
// Extracts one row of a buffered result matrix for the output port.
// With TC_DRAIN_RELU_EN defined, negative elements are clamped to zero.
module tc_row_select
   import tc_pkg::*;
(
   input  logic [MAT_W-1:0] i_mat,
   input  logic [1:0]       i_rowIdx,
   output logic [ROW_W-1:0] o_row
);

   acc_t w_elem;

   always_comb begin
      o_row  = '0;
      w_elem = '0;
      for (int j = 0; j < DIM; j++) begin
         w_elem = acc_t'(i_mat[idx(int'(i_rowIdx), j) +: ACC_WIDTH]);
`ifdef TC_DRAIN_RELU_EN
         if (w_elem < 0) begin
            w_elem = '0;
         end
`endif
         o_row[j*ACC_WIDTH +: ACC_WIDTH] = w_elem;
      end
   end

endmodule

// File: rtl/tc_result_drain.sv
// Two-entry ping-pong buffer that captures tensor-core results and streams them out row by row.
// Optional TC_DRAIN_RELU_EN clamps negative output elements (see tc_row_select).
module tc_result_drain
   import tc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [MAT_W-1:0] in_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] out_row,
   output logic [1:0]       out_row_idx,
   output logic             out_last,
   output logic             drain_ready,
   output logic             overflow_err,
   input  logic             clear_err
);

   drain_state_t r_state;
   logic         r_wrPtr;
   logic         r_rdPtr;
   logic [1:0]   r_rowIdx;
   logic         r_ovf;
   mat_t         r_buf [2];

   logic w_xfer;
   logic w_lastXfer;
   logic w_accept;
   logic w_drop;

   assign out_valid    = (r_state != EMPTY);
   assign out_row_idx  = r_rowIdx;
   assign out_last     = out_valid && (r_rowIdx == LAST_ROW);
   assign drain_ready  = (r_state != FULL);
   assign overflow_err = r_ovf;

   assign w_xfer     = out_valid && out_ready;
   assign w_lastXfer = w_xfer && (r_rowIdx == LAST_ROW);
   // A full buffer still accepts when the older matrix leaves in the same cycle.
   assign w_accept   = in_valid && ((r_state != FULL) || w_lastXfer);
   assign w_drop     = in_valid && !w_accept;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_wrPtr] <= in_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= EMPTY;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_rowIdx <= 2'd0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wrPtr <= ~r_wrPtr;
         end
         if (w_xfer) begin
            r_rowIdx <= w_lastXfer ? 2'd0 : r_rowIdx + 2'd1;
            if (w_lastXfer) begin
               r_rdPtr <= ~r_rdPtr;
            end
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clear_err) begin
            r_ovf <= 1'b0;
         end
         case ({w_accept, w_lastXfer})
            2'b10: begin
               case (r_state)
                  EMPTY:   r_state <= ONE;
                  default: r_state <= FULL;
               endcase
            end
            2'b01: begin
               case (r_state)
                  FULL:    r_state <= ONE;
                  default: r_state <= EMPTY;
               endcase
            end
            default: r_state <= r_state;
         endcase
      end
   end

   tc_row_select u_rowSelect (
      .i_mat    (r_buf[r_rdPtr]),
      .i_rowIdx (r_rowIdx),
      .o_row    (out_row)
   );

endmodule

// File: doc/tc_result_drain.md
Name: tc_result_drain

Overview:
Downstream stage of the INT8 tensor core. Captures each 4x4 INT32 result matrix D on the core's single-cycle result pulse into a two-entry ping-pong buffer. Streams the captured matrices out one row per beat on a valid/ready interface, in capture order. Drives drain_ready back to the issue logic so MMAs are only launched when a buffer slot is free.

Parameters:
DIM, 4, matrix dimension (rows, columns)
ACC_WIDTH, 32, signed accumulator element width
ROW_W, DIM*ACC_WIDTH, output row width (derived; not overridden)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
in_valid  in  1  one-cycle result pulse from tensor core (result_valid)
in_d  in  DIM*DIM*ACC_WIDTH  flattened D; element (i,j) at bits [(i*DIM+j)*ACC_WIDTH +: ACC_WIDTH]
out_valid  out  1  row available
out_ready  in  1  consumer accepts row
out_row  out  ROW_W  row data; element j at [j*ACC_WIDTH +: ACC_WIDTH]
out_row_idx  out  2  index of the current row, 0..DIM-1
out_last  out  1  high with the final row of a matrix
drain_ready  out  1  at least one buffer slot free
overflow_err  out  1  sticky: a result was dropped
clear_err  in  1  clears overflow_err

Behaviour:
- Reset (sync, rst=1 at posedge):
  - count=0, wr_ptr=0, rd_ptr=0, row_idx=0, overflow_err=0.
  - Buffer contents are don't-care.
  - Outputs while count=0: out_valid=0, out_last=0, out_row_idx=0, drain_ready=1.
- FSM, encoded by count:
  - EMPTY (0), ONE (1), FULL (2).
  - Capture: count+1. Matrix freed: count-1. Both in the same cycle: count unchanged.
- Capture:
  - in_valid accepted when count<2, or when count==2 and a final-row transfer occurs the same cycle.
  - On accept, in_d is written to buf[wr_ptr] and wr_ptr toggles.
  - Otherwise the data is dropped and overflow_err is set.
- Output:
  - out_valid = (count!=0).
  - out_row = row row_idx of buf[rd_ptr], combinational mux from registers.
  - out_last = out_valid && row_idx==DIM-1.
- Transfer = out_valid && out_ready.
  - row_idx increments.
  - On a final-row transfer: row_idx wraps to 0, rd_ptr toggles, the matrix is freed.
- While out_valid=1 and out_ready=0: out_row, out_row_idx and out_last are held stable.
- Latency: capture into EMPTY gives out_valid=1 the next cycle. Full rate is DIM beats per matrix.
- drain_ready = (count<2), combinational from registered state.
- overflow_err:
  - Set on a drop.
  - clear_err clears it.
  - A drop and clear_err in the same cycle leave it set (set wins).
- Arithmetic: none on the data path. Elements pass through bit-exact (except under the optional feature).

Optional Feature:
- TC_DRAIN_RELU_EN defined: each out_row element is clamped, negative values to 0 and non-negative values unchanged. The clamp is applied on the output mux, and buffer contents are unmodified.
- Not defined: pure pass-through, and no clamp logic is present.

Decomposition:
- tc_pkg holds:
  - DIM and ACC_WIDTH localparams
  - acc_t (logic signed [ACC_WIDTH-1:0])
  - row_t
  - an element-offset function idx(i,j) shared with the tensor core wrapper
- One sub-module, tc_row_select: combinational row extraction of a buffer entry plus the optional ReLU clamp.
- Buffer, pointers and FSM stay in the top module.

Test Plan:
- Single result, out_ready=1:
  - Input: A=2 on diagonal/1 elsewhere, B=all 1, C(0,0)=3, C(2,0)=2, C(2,2)=5.
  - Expected: rows [8 5 5 5], [5 5 5 5], [7 5 10 5], [5 5 5 5] on 4 consecutive cycles, starting 1 cycle after in_valid.
  - out_last only on row 3; drain_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles mid-matrix → row 1 data and out_row_idx=1 held stable; the stream resumes with row 2 and no loss.
- Overflow: three pulses 3 cycles apart with out_ready=0 → third dropped, overflow_err=1, drain_ready=0; the first two matrices then drain in order (8 beats); clear_err → overflow_err=0.
- Simultaneous free and capture: count=2, in_valid in the same cycle as the row-3 transfer → accepted, count stays 2, overflow_err=0, new matrix emitted after the older one.
- Reset mid-drain: rst asserted after row 1 of 2 buffered matrices → next cycle out_valid=0, drain_ready=1, overflow_err=0; a new capture restarts at row 0.
- ReLU: D element -7 → 0 with TC_DRAIN_RELU_EN, -7 without; the positive element 12 is unchanged in both builds.
